// File: rtl/video_pkg.sv
// Shared types and default constants for the frame-buffer arbiter.
// Optional feature macro used by the top: VIDEO_ARB_STARVE_EN.
package video_pkg;

    // Owner of a read travelling through the SRAM latency pipeline.
    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_LF   = 2'd1,
        TAG_CPU  = 2'd2
    } owner_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    localparam int LINE_W_DEF = 320;
    localparam int SRC_HEIGHT = 200;
    localparam int RD_LAT_DEF = 2;

endpackage

// File: rtl/video_mem_arbiter_rd_tag_pipe.sv
// Read-owner shift register: carries tag and last flag alongside SRAM latency.
// Clear is synchronous so a reset discards every in-flight read.
module rd_tag_pipe
    import video_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       i_clk,
    input  logic       i_clr,
    input  logic [1:0] i_tag,
    input  logic       i_last,
    output logic [1:0] o_tag,
    output logic       o_last,
    output logic       o_lf_pending
);

    logic [1:0] r_tag  [DEPTH];
    logic       r_last [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_tag[i]  <= TAG_NONE;
                r_last[i] <= 1'b0;
            end
        end else begin
            r_tag[0]  <= i_tag;
            r_last[0] <= i_last;
            for (int i = 1; i < DEPTH; i++) begin
                r_tag[i]  <= r_tag[i-1];
                r_last[i] <= r_last[i-1];
            end
        end
    end

    assign o_tag  = r_tag[DEPTH-1];
    assign o_last = r_last[DEPTH-1];

    // Any line-fill read still in flight keeps the burst reported as busy.
    always_comb begin
        o_lf_pending = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_tag[i] == TAG_LF) o_lf_pending = 1'b1;
        end
    end

endmodule

// File: rtl/video_mem_arbiter.sv
// Single-port frame-buffer arbiter: line-fill bursts plus PPU/CPU single accesses.
// Define VIDEO_ARB_STARVE_EN to add CPU starvation promotion over the PPU.
module video_mem_arbiter
    import video_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 24,
    parameter int LINE_W     = LINE_W_DEF,
    parameter int RD_LAT     = RD_LAT_DEF,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              lf_start,
    input  logic [ADDR_W-1:0] lf_base,
    output logic              lf_busy,
    output logic              lf_rvalid,
    output logic              lf_done,
    input  logic              ppu_req,
    input  logic              ppu_we,
    input  logic [ADDR_W-1:0] ppu_addr,
    input  logic [DATA_W-1:0] ppu_wdata,
    output logic              ppu_gnt,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] rd_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int IDX_W = (LINE_W > 1) ? $clog2(LINE_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_W - 1);

    state_t            r_state;
    logic [IDX_W-1:0]  r_idx;
    logic [ADDR_W-1:0] r_base;
    owner_t            r_iss_tag;
    logic              r_iss_last;

    logic [1:0]        w_out_tag;
    logic              w_out_last;
    logic              w_pipe_lf;
    logic              w_lf_accept;
    logic              w_ppu_gnt;
    logic              w_cpu_gnt;
    logic              w_cpu_starved;
    logic [ADDR_W-1:0] w_burst_addr;
    logic              w_burst_last;

    // Busy spans the burst plus the reads still draining out of the SRAM.
    assign lf_busy      = (r_state == ST_BURST) || (r_iss_tag == TAG_LF) || w_pipe_lf;
    assign w_lf_accept  = lf_start && !lf_busy;
    assign w_burst_addr = r_base + ADDR_W'(r_idx);
    assign w_burst_last = (r_idx == LAST_IDX);

    always_comb begin
        w_ppu_gnt = 1'b0;
        w_cpu_gnt = 1'b0;
        if (r_state == ST_IDLE && !w_lf_accept) begin
            if (cpu_req && (w_cpu_starved || !ppu_req)) begin
                w_cpu_gnt = 1'b1;
            end else if (ppu_req) begin
                w_ppu_gnt = 1'b1;
            end
        end
    end

    assign ppu_gnt = w_ppu_gnt;
    assign cpu_gnt = w_cpu_gnt;

`ifdef VIDEO_ARB_STARVE_EN
    localparam int SW = $clog2(STARVE_MAX + 1);
    logic [SW-1:0] r_starve;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_starve <= '0;
        end else if (w_cpu_gnt) begin
            r_starve <= '0;
        end else if (cpu_req && (r_starve < SW'(STARVE_MAX))) begin
            r_starve <= r_starve + SW'(1);
        end
    end

    assign w_cpu_starved = (r_starve >= SW'(STARVE_MAX));
`else
    assign w_cpu_starved = 1'b0;
`endif

    // FSM and the registered SRAM command; r_iss_* travel with mem_en.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_base     <= '0;
            r_iss_tag  <= TAG_NONE;
            r_iss_last <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            r_iss_tag  <= TAG_NONE;
            r_iss_last <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_lf_accept) begin
                        r_state <= ST_BURST;
                        r_idx   <= '0;
                        r_base  <= lf_base;
                    end else if (w_cpu_gnt) begin
                        mem_en    <= 1'b1;
                        mem_we    <= cpu_we;
                        mem_addr  <= cpu_addr;
                        mem_wdata <= cpu_wdata;
                        r_iss_tag <= cpu_we ? TAG_NONE : TAG_CPU;
                    end else if (w_ppu_gnt) begin
                        mem_en    <= 1'b1;
                        mem_we    <= ppu_we;
                        mem_addr  <= ppu_addr;
                        mem_wdata <= ppu_wdata;
                    end
                end
                ST_BURST: begin
                    mem_en     <= 1'b1;
                    mem_addr   <= w_burst_addr;
                    r_iss_tag  <= TAG_LF;
                    r_iss_last <= w_burst_last;
                    if (w_burst_last) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    rd_tag_pipe #(
        .DEPTH (RD_LAT)
    ) u_rd_tag_pipe (
        .i_clk        (clk_in),
        .i_clr        (reset),
        .i_tag        (r_iss_tag),
        .i_last       (r_iss_last),
        .o_tag        (w_out_tag),
        .o_last       (w_out_last),
        .o_lf_pending (w_pipe_lf)
    );

    assign lf_rvalid  = (w_out_tag == TAG_LF);
    assign cpu_rvalid = (w_out_tag == TAG_CPU);
    assign lf_done    = (w_out_tag == TAG_LF) && w_out_last;
    assign rd_data    = mem_rdata;

endmodule

// File: tb/tb_video_mem_arbiter.sv
// Directed bench for video_mem_arbiter with an SRAM model and address/data scoreboard.
module tb_video_mem_arbiter;
  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 24;
  localparam int LINE_W     = 320;
  localparam int RD_LAT     = 2;
  localparam int STARVE_MAX = 8;

  logic              clk_in = 1'b0;
  logic              reset;
  logic              lf_start;
  logic [ADDR_W-1:0] lf_base;
  logic              lf_busy, lf_rvalid, lf_done;
  logic              ppu_req, ppu_we, ppu_gnt;
  logic [ADDR_W-1:0] ppu_addr;
  logic [DATA_W-1:0] ppu_wdata;
  logic              cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] rd_data;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  video_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_W(LINE_W), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk_in(clk_in), .reset(reset),
    .lf_start(lf_start), .lf_base(lf_base), .lf_busy(lf_busy), .lf_rvalid(lf_rvalid), .lf_done(lf_done),
    .ppu_req(ppu_req), .ppu_we(ppu_we), .ppu_addr(ppu_addr), .ppu_wdata(ppu_wdata), .ppu_gnt(ppu_gnt),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt),
    .cpu_rvalid(cpu_rvalid), .rd_data(rd_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // clock / cycle counter
  always #5 clk_in = ~clk_in;
  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // SRAM model: data for the command seen in cycle C is on mem_rdata in C+RD_LAT
  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return {a[7:0] ^ 8'hC3, a};
  endfunction

  logic [ADDR_W-1:0] p_addr [RD_LAT];
  always @(posedge clk_in) begin
    p_addr[0] <= mem_addr;
    for (int i = 1; i < RD_LAT; i++) p_addr[i] <= p_addr[i-1];
  end
  assign mem_rdata = mem_word(p_addr[RD_LAT-1]);

  // scoreboard state
  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [DATA_W-1:0] exp_data_q[$];
  logic [DATA_W-1:0] exp_cpu_q[$];
  int checks = 0;
  int failures = 0;
  int rd_cnt = 0, lfrv_cnt = 0, done_cnt = 0, done_cyc = 0, cpu_rv_cnt = 0, cpu_rv_cyc = 0;
  logic done_seen = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // monitor: sampled on the falling edge, away from the active edge
  always @(negedge clk_in) begin
    if (mem_en === 1'b1 && mem_we === 1'b0) begin
      rd_cnt++;
      check("rd_expected", 32'(exp_addr_q.size() > 0), 1);
      if (exp_addr_q.size() > 0) check("rd_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
    end
    if (lf_rvalid === 1'b1) begin
      lfrv_cnt++;
      check("lf_rv_expected", 32'(exp_data_q.size() > 0), 1);
      if (exp_data_q.size() > 0) check("lf_rd_data", 32'(rd_data), 32'(exp_data_q.pop_front()));
    end
    if (cpu_rvalid === 1'b1) begin
      cpu_rv_cnt++;
      cpu_rv_cyc = cyc;
      check("cpu_rv_expected", 32'(exp_cpu_q.size() > 0), 1);
      if (exp_cpu_q.size() > 0) check("cpu_rd_data", 32'(rd_data), 32'(exp_cpu_q.pop_front()));
    end
    if (lf_done === 1'b1) begin
      done_cnt++;
      done_seen = 1'b1;
      done_cyc = cyc;
    end
  end

  task automatic run_burst(input logic [ADDR_W-1:0] base, input int restart_at);
    int s;
    logic [ADDR_W-1:0] a;
    lf_base = base;
    lf_start = 1'b1;
    s = cyc;
    for (int i = 0; i < LINE_W; i++) begin
      a = base + ADDR_W'(i);
      exp_addr_q.push_back(a);
      exp_data_q.push_back(mem_word(a));
    end
    rd_cnt = 0; lfrv_cnt = 0; done_cnt = 0; done_seen = 1'b0;
    tick();
    lf_start = 1'b0;
    lf_base = base ^ 16'h5555;
    check("burst_busy_s1", 32'(lf_busy), 1);
    for (int i = 0; i < 400 && !done_seen; i++) begin
      lf_start = (restart_at > 0) && (cyc == s + restart_at);
      tick();
    end
    lf_start = 1'b0;
    check("burst_done_seen", 32'(done_seen), 1);
    check("burst_done_cycle", done_cyc, s + LINE_W + 1 + RD_LAT);
    check("burst_done_count", done_cnt, 1);
    check("burst_busy_after", 32'(lf_busy), 0);
    check("burst_mem_en_after", 32'(mem_en), 0);
    check("burst_reads", rd_cnt, LINE_W);
    check("burst_lf_rvalid", lfrv_cnt, LINE_W);
    check("burst_addr_q_empty", exp_addr_q.size(), 0);
    check("burst_data_q_empty", exp_data_q.size(), 0);
  endtask

  logic exp_c;
  int s, t, first_gnt, gnt_in_burst;
  logic [ADDR_W-1:0] a;

  initial begin
    reset = 1'b1; lf_start = 1'b0; lf_base = '0;
    ppu_req = 1'b0; ppu_we = 1'b0; ppu_addr = '0; ppu_wdata = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    repeat (3) tick();

    // reset state
    check("rst_mem_en", 32'(mem_en), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_wdata", 32'(mem_wdata), 0);
    check("rst_lf_busy", 32'(lf_busy), 0);
    check("rst_lf_done", 32'(lf_done), 0);
    check("rst_lf_rvalid", 32'(lf_rvalid), 0);
    check("rst_cpu_rvalid", 32'(cpu_rvalid), 0);
    check("rst_gnts", 32'({ppu_gnt, cpu_gnt}), 0);
    reset = 1'b0;
    tick();

    // starvation: both requesters writing continuously
    ppu_req = 1'b1; ppu_we = 1'b1; ppu_addr = 16'h0AAA; ppu_wdata = 24'h111111;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0BBB; cpu_wdata = 24'h222222;
    for (int k = 1; k <= 12; k++) begin
      #1;
`ifdef VIDEO_ARB_STARVE_EN
      exp_c = (k == STARVE_MAX + 1);
`else
      exp_c = 1'b0;
`endif
      check("starve_cpu_gnt", 32'(cpu_gnt), 32'(exp_c));
      check("starve_ppu_gnt", 32'(ppu_gnt), 32'(!exp_c));
      tick();
      check("starve_mem_en", 32'(mem_en), 1);
      check("starve_mem_we", 32'(mem_we), 1);
      check("starve_mem_addr", 32'(mem_addr), exp_c ? 'h0BBB : 'h0AAA);
      check("starve_mem_wdata", 32'(mem_wdata), exp_c ? 'h222222 : 'h111111);
    end
    ppu_req = 1'b0; cpu_req = 1'b0;
    tick();
    tick();
    check("idle_mem_en", 32'(mem_en), 0);
    check("idle_addr_hold", 32'(mem_addr), exp_c ? 'h0BBB : 'h0AAA);

    // CPU single read
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0123; t = cyc;
    exp_addr_q.push_back(16'h0123);
    exp_cpu_q.push_back(mem_word(16'h0123));
    cpu_rv_cnt = 0;
    #1;
    check("cpu_rd_gnt", 32'(cpu_gnt), 1);
    tick();
    cpu_req = 1'b0;
    check("cpu_rd_mem_we", 32'(mem_we), 0);
    for (int i = 0; i < 10 && cpu_rv_cnt == 0; i++) tick();
    check("cpu_rv_count", cpu_rv_cnt, 1);
    check("cpu_rv_cycle", cpu_rv_cyc, t + 1 + RD_LAT);
    tick();

    // line-fill burst at 0x1000 with an ignored restart mid-burst
    run_burst(16'h1000, 50);
    tick();

    // address wrap with both requesters blocked by the burst
    lf_base = 16'hFF80; lf_start = 1'b1;
    ppu_req = 1'b1; ppu_we = 1'b1; ppu_addr = 16'h0AAA;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0BBB;
    s = cyc;
    for (int i = 0; i < LINE_W; i++) begin
      a = 16'hFF80 + ADDR_W'(i);
      exp_addr_q.push_back(a);
      exp_data_q.push_back(mem_word(a));
    end
    rd_cnt = 0; lfrv_cnt = 0; done_cnt = 0; done_seen = 1'b0;
    first_gnt = 0; gnt_in_burst = 0;
    #1;
    check("wrap_gnt_at_start", 32'({ppu_gnt, cpu_gnt}), 0);
    tick();
    lf_start = 1'b0;
    for (int i = 0; i < 400 && !done_seen; i++) begin
      #1;
      if ((ppu_gnt || cpu_gnt) && first_gnt == 0) first_gnt = cyc;
      if (cyc <= s + LINE_W && (ppu_gnt || cpu_gnt)) gnt_in_burst++;
      if (cyc == s + LINE_W + 1) check("wrap_one_gnt", 32'(ppu_gnt) + 32'(cpu_gnt), 1);
      if (cyc == s + LINE_W + 2) begin
        ppu_req = 1'b0; cpu_req = 1'b0;
      end
      tick();
    end
    ppu_req = 1'b0; cpu_req = 1'b0;
    check("wrap_no_gnt_in_burst", gnt_in_burst, 0);
    check("wrap_first_gnt_cycle", first_gnt, s + LINE_W + 1);
    check("wrap_done_cycle", done_cyc, s + LINE_W + 1 + RD_LAT);
    check("wrap_reads", rd_cnt, LINE_W);
    check("wrap_lf_rvalid", lfrv_cnt, LINE_W);
    check("wrap_addr_q_empty", exp_addr_q.size(), 0);
    tick();
    tick();

    // reset while idx=100 is being issued
    lf_base = 16'h3000; lf_start = 1'b1; s = cyc;
    for (int i = 0; i < 100; i++) begin
      a = 16'h3000 + ADDR_W'(i);
      exp_addr_q.push_back(a);
      if (i < 98) exp_data_q.push_back(mem_word(a));
    end
    rd_cnt = 0; lfrv_cnt = 0; done_cnt = 0; done_seen = 1'b0;
    tick();
    lf_start = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstmid_mem_en", 32'(mem_en), 0);
    check("rstmid_busy", 32'(lf_busy), 0);
    for (int i = 0; i < 30; i++) tick();
    check("rstmid_no_done", done_cnt, 0);
    check("rstmid_reads", rd_cnt, 100);
    check("rstmid_rvalid", lfrv_cnt, 98);
    check("rstmid_addr_q_empty", exp_addr_q.size(), 0);
    check("rstmid_data_q_empty", exp_data_q.size(), 0);

    // a full burst still runs after the mid-burst reset
    run_burst(16'h4000, 0);
    tick();
    check("final_cpu_q_empty", exp_cpu_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
